sw_dispatch: RTL and testbench

SW_DISPATCH -- requirements
Module: sw_dispatch

---
 rtl/sw_dispatch_pkg.sv | 18 +
 rtl/sw_dispatch.sv | 153 +++++++++++++++
 tb/tb_sw_dispatch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_dispatch_pkg.sv
// Shared bridge constants for the SWRITE dispatcher: FSM encodings, chunking
// geometry and fixed AXI read-address attributes.
package sw_dispatch_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int MAX_CHUNK_BYTES = 256;
  localparam int BEAT_BYTES      = 8;
  localparam int BEAT_SHIFT      = $clog2(BEAT_BYTES);

  localparam logic [2:0] AR_SIZE_8B    = 3'b011;
  localparam logic [1:0] AR_BURST_INCR = 2'b01;

endpackage

// File: rtl/sw_dispatch.sv
// Splits a byte-length command into <=256-byte SWRITE chunks, optionally
// fetching each chunk over AXI, and sequences the transmit engine per chunk.
module sw_dispatch
  import sw_dispatch_pkg::*;
#(
  parameter int C_LEN_WIDTH = 20
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_mode,
  input  logic [31:0]            cmd_src_addr,
  input  logic [31:0]            cmd_dst_addr,
  input  logic [C_LEN_WIDTH-1:0] cmd_len,
  output logic                   cmd_done,
  output logic                   cmd_err,
  output logic                   busy,
  output logic                   sw_start,
  output logic                   sw_mode,
  output logic [4:0]             sw_size,
  output logic [31:0]            sw_addr,
  input  logic                   sw_done,
  output logic [31:0]            m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready
);

  logic [2:0]             state;
  logic [31:0]            src_addr;
  logic [31:0]            dst_addr;
  logic [C_LEN_WIDTH-1:0] remaining;
  logic                   mode;
  logic [8:0]             chunk;
  logic                   ar_ok;
  logic                   sw_ok;

  logic [8:0]             chunk_n;
  logic                   ar_ok_n;
  logic                   sw_ok_n;
  logic                   cmd_bad;

  // mm2sw chunks must not cross a 256-byte source boundary; s2sw only caps length.
  function automatic logic [8:0] calc_chunk(input logic                   m,
                                            input logic [31:0]            src,
                                            input logic [C_LEN_WIDTH-1:0] rem);
    logic [8:0] cap;
    cap = m ? (9'(MAX_CHUNK_BYTES) - {1'b0, src[7:0]}) : 9'(MAX_CHUNK_BYTES);
    if (rem < C_LEN_WIDTH'(cap)) return rem[8:0];
    else                         return cap;
  endfunction

  assign chunk_n = calc_chunk(mode, src_addr, remaining);
  assign ar_ok_n = ar_ok | (m_axi_arvalid & m_axi_arready);
  assign sw_ok_n = sw_ok | sw_done;
  assign cmd_bad = (cmd_len == '0) || (cmd_len[2:0] != 3'd0) ||
                   (cmd_dst_addr[2:0] != 3'd0) ||
                   (cmd_mode && (cmd_src_addr[2:0] != 3'd0));

  assign cmd_ready     = (state == S_IDLE) && !areset;
  assign busy          = (state != S_IDLE);
  assign m_axi_arsize  = AR_SIZE_8B;
  assign m_axi_arburst = AR_BURST_INCR;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= S_IDLE;
      src_addr      <= '0;
      dst_addr      <= '0;
      remaining     <= '0;
      mode          <= 1'b0;
      chunk         <= '0;
      ar_ok         <= 1'b0;
      sw_ok         <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_err       <= 1'b0;
      sw_start      <= 1'b0;
      sw_mode       <= 1'b0;
      sw_size       <= '0;
      sw_addr       <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
    end else begin
      sw_start <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              cmd_err <= 1'b1;
            end else begin
              src_addr  <= cmd_src_addr;
              dst_addr  <= cmd_dst_addr;
              remaining <= cmd_len;
              mode      <= cmd_mode;
              state     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          chunk         <= chunk_n;
          sw_size       <= 5'((chunk_n >> BEAT_SHIFT) - 9'd1);
          m_axi_arlen   <= {3'b000, 5'((chunk_n >> BEAT_SHIFT) - 9'd1)};
          sw_addr       <= dst_addr;
          sw_mode       <= mode;
          m_axi_araddr  <= src_addr;
          sw_start      <= 1'b1;
          m_axi_arvalid <= mode;
          ar_ok         <= ~mode;
          sw_ok         <= 1'b0;
          state         <= S_ISSUE;
        end
        S_ISSUE: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            ar_ok         <= 1'b1;
          end
          if (sw_done) sw_ok <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            ar_ok         <= 1'b1;
          end
          if (sw_done) sw_ok <= 1'b1;
          // chunk <= remaining by construction, so the subtraction cannot wrap
          if (ar_ok_n && sw_ok_n) begin
            src_addr  <= src_addr + 32'(chunk);
            dst_addr  <= dst_addr + 32'(chunk);
            remaining <= remaining - C_LEN_WIDTH'(chunk);
            ar_ok     <= 1'b0;
            sw_ok     <= 1'b0;
            if (remaining == C_LEN_WIDTH'(chunk)) begin
              cmd_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_dispatch.sv
// Directed bench for sw_dispatch: chunking, AR handshake, rejection and reset.
module tb_sw_dispatch;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_mode;
  logic [31:0] cmd_src_addr;
  logic [31:0] cmd_dst_addr;
  logic [19:0] cmd_len;
  logic        cmd_done;
  logic        cmd_err;
  logic        busy;
  logic        sw_start;
  logic        sw_mode;
  logic [4:0]  sw_size;
  logic [31:0] sw_addr;
  logic        sw_done;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_arv    = 0;
  int n_done   = 0;
  int base_start;
  int base_arv;
  int base_done;

  logic [31:0] exp_araddr[3] = '{32'h2080, 32'h2100, 32'h2200};
  logic [31:0] exp_swaddr[3] = '{32'h0000, 32'h0080, 32'h0180};
  logic [4:0]  exp_size[3]   = '{5'd15, 5'd31, 5'd15};

  sw_dispatch #(.C_LEN_WIDTH(20)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy),
    .sw_start(sw_start), .sw_mode(sw_mode), .sw_size(sw_size), .sw_addr(sw_addr),
    .sw_done(sw_done),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (sw_start)      n_start <= n_start + 1;
    if (m_axi_arvalid) n_arv   <= n_arv + 1;
    if (cmd_done)      n_done  <= n_done + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic m, input logic [31:0] src, input logic [31:0] dst,
                          input logic [19:0] len);
    check_eq("ready_before_cmd", cmd_ready, 1'b1);
    cmd_mode     = m;
    cmd_src_addr = src;
    cmd_dst_addr = dst;
    cmd_len      = len;
    cmd_valid    = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    areset = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_src_addr = '0;
    cmd_dst_addr = '0; cmd_len = '0; sw_done = 1'b0; m_axi_arready = 1'b0;
    repeat (3) step();
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sw_start", sw_start, 1'b0);
    check_eq("rst_arvalid", m_axi_arvalid, 1'b0);
    check_eq("rst_sw_addr", sw_addr, 32'h0);
    check_eq("rst_araddr", m_axi_araddr, 32'h0);
    check_eq("rst_arlen", m_axi_arlen, 8'h0);
    check_eq("rst_sw_size", sw_size, 5'h0);
    check_eq("rst_cmd_done", cmd_done, 1'b0);
    check_eq("arsize", m_axi_arsize, 3'b011);
    check_eq("arburst", m_axi_arburst, 2'b01);
    areset = 1'b0;
    step();
    check_eq("post_rst_ready", cmd_ready, 1'b1);

    // single s2sw chunk
    base_start = n_start; base_arv = n_arv; base_done = n_done;
    send_cmd(1'b0, 32'h0, 32'h1000, 20'd64);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_ready_low", cmd_ready, 1'b0);
    check_eq("t1_no_start_calc", sw_start, 1'b0);
    step();
    check_eq("t1_sw_start", sw_start, 1'b1);
    check_eq("t1_sw_size", sw_size, 5'd7);
    check_eq("t1_sw_addr", sw_addr, 32'h1000);
    check_eq("t1_sw_mode", sw_mode, 1'b0);
    step();
    check_eq("t1_start_pulse", sw_start, 1'b0);
    step();
    check_eq("t1_wait_no_done", cmd_done, 1'b0);
    sw_done = 1'b1;
    step();
    sw_done = 1'b0;
    check_eq("t1_cmd_done", cmd_done, 1'b1);
    step();
    check_eq("t1_done_pulse", cmd_done, 1'b0);
    check_eq("t1_idle_ready", cmd_ready, 1'b1);
    check_eq("t1_idle_busy", busy, 1'b0);
    check_eq("t1_n_start", n_start - base_start, 1);
    check_eq("t1_no_arvalid", n_arv - base_arv, 0);
    check_eq("t1_n_done", n_done - base_done, 1);

    // mm2sw with a 256-byte source boundary split: 128/256/128
    base_start = n_start;
    send_cmd(1'b1, 32'h2080, 32'h0, 20'd512);
    step();
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_sw_start", sw_start, 1'b1);
      check_eq("t2_sw_size", sw_size, exp_size[i]);
      check_eq("t2_arlen", m_axi_arlen, {3'b000, exp_size[i]});
      check_eq("t2_araddr", m_axi_araddr, exp_araddr[i]);
      check_eq("t2_sw_addr", sw_addr, exp_swaddr[i]);
      check_eq("t2_arvalid", m_axi_arvalid, 1'b1);
      check_eq("t2_sw_mode", sw_mode, 1'b1);
      m_axi_arready = 1'b1;
      step();
      m_axi_arready = 1'b0;
      check_eq("t2_arvalid_drop", m_axi_arvalid, 1'b0);
      sw_done = 1'b1;
      step();
      sw_done = 1'b0;
      if (i < 2) begin
        check_eq("t2_mid_no_done", cmd_done, 1'b0);
        check_eq("t2_calc_no_start", sw_start, 1'b0);
        step();
      end else begin
        check_eq("t2_cmd_done", cmd_done, 1'b1);
      end
    end
    step();
    check_eq("t2_n_start", n_start - base_start, 3);

    // AR stalled for 10 cycles
    base_start = n_start;
    send_cmd(1'b1, 32'h3000, 32'h40, 20'd32);
    step();
    check_eq("t3_sw_size", sw_size, 5'd3);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("t3_arvalid_hold", m_axi_arvalid, 1'b1);
      check_eq("t3_araddr_hold", m_axi_araddr, 32'h3000);
      check_eq("t3_arlen_hold", m_axi_arlen, 8'd3);
      check_eq("t3_sw_addr_hold", sw_addr, 32'h40);
    end
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    check_eq("t3_arvalid_drop", m_axi_arvalid, 1'b0);
    check_eq("t3_no_done_wo_sw", cmd_done, 1'b0);
    step();
    check_eq("t3_still_busy", busy, 1'b1);
    sw_done = 1'b1;
    step();
    sw_done = 1'b0;
    check_eq("t3_cmd_done", cmd_done, 1'b1);
    step();
    check_eq("t3_n_start", n_start - base_start, 1);

    // rejected commands
    base_start = n_start;
    send_cmd(1'b0, 32'h0, 32'h0, 20'd12);
    check_eq("t4_err_len12", cmd_err, 1'b1);
    check_eq("t4_ready_len12", cmd_ready, 1'b1);
    step();
    check_eq("t4_err_pulse", cmd_err, 1'b0);
    send_cmd(1'b0, 32'h0, 32'h0, 20'd0);
    check_eq("t4_err_len0", cmd_err, 1'b1);
    check_eq("t4_busy_len0", busy, 1'b0);
    step();
    send_cmd(1'b1, 32'h4, 32'h0, 20'd8);
    check_eq("t4_err_src", cmd_err, 1'b1);
    step();
    send_cmd(1'b0, 32'h0, 32'h2, 20'd8);
    check_eq("t4_err_dst", cmd_err, 1'b1);
    step();
    check_eq("t4_no_start", n_start - base_start, 0);

    // reset during WAIT of chunk 2 of 3
    base_done = n_done;
    send_cmd(1'b0, 32'h0, 32'h8000, 20'd768);
    step();
    step();
    sw_done = 1'b1;
    step();
    sw_done = 1'b0;
    step();
    check_eq("t5_chunk2_addr", sw_addr, 32'h8100);
    step();
    areset = 1'b1;
    step();
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_ready", cmd_ready, 1'b0);
    check_eq("t5_rst_sw_addr", sw_addr, 32'h0);
    check_eq("t5_rst_sw_size", sw_size, 5'h0);
    areset = 1'b0;
    step();
    check_eq("t5_ready_after", cmd_ready, 1'b1);
    check_eq("t5_no_done", n_done - base_done, 0);
    sw_done = 1'b1;
    step();
    sw_done = 1'b0;
    check_eq("t5_idle_ignores_sw_done", busy, 1'b0);
    send_cmd(1'b0, 32'h0, 32'h10, 20'd8);
    step();
    check_eq("t5_new_size", sw_size, 5'd0);
    check_eq("t5_new_addr", sw_addr, 32'h10);
    sw_done = 1'b1;
    step();
    step();
    sw_done = 1'b0;
    check_eq("t5_new_done", cmd_done, 1'b1);
    step();

    // arready coincident with sw_done
    send_cmd(1'b1, 32'h100, 32'h200, 20'd264);
    step();
    check_eq("t6_size0", sw_size, 5'd31);
    check_eq("t6_araddr0", m_axi_araddr, 32'h100);
    step();
    m_axi_arready = 1'b1; sw_done = 1'b1;
    step();
    m_axi_arready = 1'b0; sw_done = 1'b0;
    check_eq("t6_arvalid_drop", m_axi_arvalid, 1'b0);
    check_eq("t6_calc_no_start", sw_start, 1'b0);
    step();
    check_eq("t6_start2", sw_start, 1'b1);
    check_eq("t6_araddr1", m_axi_araddr, 32'h200);
    check_eq("t6_arlen1", m_axi_arlen, 8'd0);
    check_eq("t6_sw_addr1", sw_addr, 32'h300);
    m_axi_arready = 1'b1; sw_done = 1'b1;
    step();
    m_axi_arready = 1'b0; sw_done = 1'b0;
    check_eq("t6_issue_no_done", cmd_done, 1'b0);
    step();
    check_eq("t6_cmd_done", cmd_done, 1'b1);
    step();
    check_eq("t6_final_ready", cmd_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
